// File: rtl/if_id_buffer.sv
// IF->ID decoupling queue: registered head outputs (1-cycle fill latency), if_hold keeps a slot for the in-flight fetch.
// Optional sticky overflow flag `ovf` when IF_ID_BUFFER_OVF_EN is defined; default build silently drops overflow words.
module if_id_buffer #(
  parameter int ADDR_WIDTH   = 32,
  parameter int INST_WIDTH   = 32,
  parameter int DEPTH        = 4,
  parameter int FLUSH_SHADOW = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_valid,
  input  logic [INST_WIDTH-1:0] inst_i,
  input  logic [ADDR_WIDTH-1:0] pc_plus4_i,
  input  logic                  id_stall,
  input  logic                  flush,
  output logic                  valid_o,
  output logic [INST_WIDTH-1:0] inst_o,
  output logic [ADDR_WIDTH-1:0] pc_plus4_o,
  output logic                  if_hold
`ifdef IF_ID_BUFFER_OVF_EN
  ,
  output logic                  ovf
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] HOLD_CNT = CNT_W'(DEPTH - 1);
  localparam logic SHADOW_EN = (FLUSH_SHADOW != 0);

  logic [INST_WIDTH-1:0] inst_mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] pc_mem_q   [DEPTH];

  logic [CNT_W-1:0] count_q, count_d, count_next;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic             shadow_q, shadow_d;
  logic             full, push, pop;

  always_comb begin
    full       = (count_q == FULL_CNT);
    valid_o    = (count_q != '0);
    push       = fetch_valid & ~flush & ~shadow_q & ~full;
    pop        = valid_o & ~id_stall & ~flush;
    count_next = count_q + CNT_W'(push) - CNT_W'(pop);
    // Hold one entry early: the ROM word already in flight still needs a free slot.
    if_hold    = ~flush & (count_next >= HOLD_CNT);

    count_d  = count_next;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    shadow_d = flush & SHADOW_EN;
    if (flush) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end

    inst_o     = valid_o ? inst_mem_q[rd_ptr_q] : '0;
    pc_plus4_o = valid_o ? pc_mem_q[rd_ptr_q]   : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      shadow_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      shadow_q <= shadow_d;
    end
  end

  // Storage needs no reset: outputs are masked whenever the queue is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem_q[wr_ptr_q] <= inst_i;
      pc_mem_q[wr_ptr_q]   <= pc_plus4_i;
    end
  end

`ifdef IF_ID_BUFFER_OVF_EN
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q | (fetch_valid & full & ~flush & ~shadow_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_if_id_buffer.sv
// Scoreboard bench for if_id_buffer: directed stimulus pushes expected words, a negedge monitor checks pops.
module tb_if_id_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_valid;
  logic [31:0] inst_i;
  logic [31:0] pc_plus4_i;
  logic        id_stall;
  logic        flush;
  logic        valid_o;
  logic [31:0] inst_o;
  logic [31:0] pc_plus4_o;
  logic        if_hold;
`ifdef IF_ID_BUFFER_OVF_EN
  logic        ovf;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] expq [$];

  if_id_buffer #(
    .ADDR_WIDTH(32), .INST_WIDTH(32), .DEPTH(4), .FLUSH_SHADOW(1)
  ) dut (
    .clk(clk), .rst(rst), .fetch_valid(fetch_valid), .inst_i(inst_i),
    .pc_plus4_i(pc_plus4_i), .id_stall(id_stall), .flush(flush),
    .valid_o(valid_o), .inst_o(inst_o), .pc_plus4_o(pc_plus4_o),
    .if_hold(if_hold)
`ifdef IF_ID_BUFFER_OVF_EN
    , .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One cycle: drive at posedge+1, check comb/registered outputs at posedge+2.
  // ev/eh are expected valid_o / if_hold, -1 to skip.
  task automatic step(input string tag, input bit f, input logic [31:0] i, input bit s,
                      input bit fl, input bit acc, input int ev, input int eh);
    fetch_valid = f;
    inst_i      = i;
    pc_plus4_i  = i + 32'h1000;
    id_stall    = s;
    flush       = fl;
    if (fl) expq.delete();
    if (acc) expq.push_back({i + 32'h1000, i});
    #1;
    if (ev >= 0) chk({tag, ".valid_o"}, 64'(valid_o), 64'(ev));
    if (eh >= 0) chk({tag, ".if_hold"}, 64'(if_hold), 64'(eh));
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (valid_o) begin
        if (!id_stall && !flush) begin
          chk("mon.queue_nonempty", 64'(expq.size() > 0), 64'd1);
          if (expq.size() > 0) begin
            chk("mon.inst_o", 64'(inst_o), 64'(expq[0][31:0]));
            chk("mon.pc_plus4_o", 64'(pc_plus4_o), 64'(expq[0][63:32]));
            void'(expq.pop_front());
          end
        end
      end else begin
        chk("mon.idle_zero", {pc_plus4_o, inst_o}, 64'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; fetch_valid = 1'b0; inst_i = '0; pc_plus4_i = '0;
    id_stall = 1'b0; flush = 1'b0;
    #12;
    chk("reset.outputs", {31'd0, valid_o, inst_o}, 64'd0);
    chk("reset.pc_hold", {31'd0, if_hold, pc_plus4_o}, 64'd0);
`ifdef IF_ID_BUFFER_OVF_EN
    chk("reset.ovf", 64'(ovf), 64'd0);
`endif
    rst = 1'b0;
    @(posedge clk); #1;

    // Stream 0x11..0x16 with no stall
    step("stream1", 1, 32'h11, 0, 0, 1, 0, 0);
    for (int k = 1; k < 6; k++) step("stream", 1, 32'h11 + 32'(k), 0, 0, 1, 1, 0);
    step("stream_tail", 0, 0, 0, 0, 0, 1, 0);
    step("stream_idle", 0, 0, 0, 0, 0, 0, 0);

    // Backpressure
    step("bp1", 1, 32'h21, 1, 0, 1, 0, 0);
    step("bp2", 1, 32'h22, 1, 0, 1, 1, 0);
    step("bp3", 1, 32'h23, 1, 0, 1, 1, 1);
    step("bp_hold", 0, 0, 1, 0, 0, 1, 1);
    step("bp_rel1", 0, 0, 0, 0, 0, 1, 0);
    step("bp_rel2", 0, 0, 0, 0, 0, 1, 0);
    step("bp_rel3", 0, 0, 0, 0, 0, 1, 0);
    step("bp_empty", 0, 0, 0, 0, 0, 0, 0);

    // Flush with wrong-path words 0x99 (flush cycle) and 0x98 (shadow)
    step("fl_q1", 1, 32'h31, 1, 0, 1, 0, 0);
    step("fl_q2", 1, 32'h32, 1, 0, 1, 1, 0);
    step("fl_q3", 1, 32'h33, 1, 0, 1, 1, 1);
    step("fl_flush", 1, 32'h99, 1, 1, 0, 1, 0);
    step("fl_shadow", 1, 32'h98, 0, 0, 0, 0, 0);
    step("fl_after", 0, 0, 0, 0, 0, 0, 0);

    // Flush during shadow re-arms it
    step("rearm_f1", 1, 32'h97, 0, 1, 0, 0, 0);
    step("rearm_f2", 1, 32'h96, 0, 1, 0, 0, 0);
    step("rearm_sh", 1, 32'h95, 0, 0, 0, 0, 0);
    step("rearm_ok", 1, 32'h41, 0, 0, 1, 0, 0);
    step("rearm_out", 0, 0, 0, 0, 0, 1, 0);
    step("rearm_idle", 0, 0, 0, 0, 0, 0, 0);

    // Wrap: 10 push/pop pairs
    for (int k = 0; k < 10; k++) begin
      step("wrap_push", 1, 32'h50 + 32'(k), 1, 0, 1, 0, 0);
      step("wrap_pop", 0, 0, 0, 0, 0, 1, 0);
    end
    step("wrap_idle", 0, 0, 0, 0, 0, 0, 0);
`ifdef IF_ID_BUFFER_OVF_EN
    chk("ovf_before", 64'(ovf), 64'd0);
`endif

    // Overflow: ignore if_hold, fifth word dropped
    step("ovf_p1", 1, 32'h61, 1, 0, 1, 0, 0);
    step("ovf_p2", 1, 32'h62, 1, 0, 1, 1, 0);
    step("ovf_p3", 1, 32'h63, 1, 0, 1, 1, 1);
    step("ovf_p4", 1, 32'h64, 1, 0, 1, 1, 1);
`ifdef IF_ID_BUFFER_OVF_EN
    chk("ovf_at_full", 64'(ovf), 64'd0);
`endif
    step("ovf_p5", 1, 32'h65, 1, 0, 0, 1, 1);
`ifdef IF_ID_BUFFER_OVF_EN
    chk("ovf_set", 64'(ovf), 64'd1);
`endif
    step("ovf_d1", 0, 0, 0, 0, 0, 1, 1);
    step("ovf_d2", 0, 0, 0, 0, 0, 1, 0);
    step("ovf_d3", 0, 0, 0, 0, 0, 1, 0);
    step("ovf_d4", 0, 0, 0, 0, 0, 1, 0);
    step("ovf_empty", 0, 0, 0, 0, 0, 0, 0);
`ifdef IF_ID_BUFFER_OVF_EN
    chk("ovf_sticky", 64'(ovf), 64'd1);
`endif

    // Asynchronous reset mid-stream
    step("ar_p1", 1, 32'h71, 1, 0, 1, 0, 0);
    step("ar_p2", 1, 32'h72, 1, 0, 1, 1, 0);
    fetch_valid = 1'b0;
    chk("ar_pre_valid", 64'(valid_o), 64'd1);
    #2;
    rst = 1'b1;
    expq.delete();
    #1;
    chk("ar_valid_inst", {31'd0, valid_o, inst_o}, 64'd0);
    chk("ar_pc_hold", {31'd0, if_hold, pc_plus4_o}, 64'd0);
`ifdef IF_ID_BUFFER_OVF_EN
    chk("ar_ovf", 64'(ovf), 64'd0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    step("ar_after", 0, 0, 0, 0, 0, 0, 0);
    step("ar_fresh", 1, 32'h81, 0, 0, 1, 0, 0);
    step("ar_fresh_out", 0, 0, 0, 0, 0, 1, 0);
    step("ar_idle", 0, 0, 0, 0, 0, 0, 0);

    chk("scoreboard_drained", 64'(expq.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
